mips_pipe_ctrl: RTL and testbench
=================================

MIPS_PIPE_CTRL -- requirements
Module: mips_pipe_ctrl

Interface
REQ-001 SHALL have the following ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin execution (sampled in IDLE only)
- ir_id  in  32  instruction in ID stage
- ir_ex  in  32  instruction in EX stage
- cond_ex  in  1  branch taken, resolved in EX
- mem_ready  in  1  data memory handshake; 0 = access not complete
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register load enables
- ifid_flush, idex_flush  out  1 each  load NOP into that pipeline register
- busy  out  1  state is RUN or DRAIN
- halted  out  1  state is HALT
- stall_cnt  out  16  performance counter of stalled cycles
REQ-002 SHALL decode fields as opcode=ir[31:26], rs=ir[25:21], rt=ir[20:16].
REQ-003 SHALL use these opcodes: R-type ALU 000000-000101, LW 001000, SW 001001, ADDI/SUBI/SLTI 001010-001100, BNEZ 001101, BEQZ 001110, HLT 111111.

Function
REQ-004 SHALL implement FSM IDLE(00) -> RUN(01) -> DRAIN(10) -> HALT(11); state registered, outputs combinational from state and inputs.
REQ-005 IDLE: all enables and flushes 0; start=1 -> RUN next cycle, with stall_cnt cleared on that transition.
REQ-006 RUN: default all five enables 1, flushes 0.
REQ-007 RUN, mem_ready=0 (freeze, highest priority): all enables 0, flushes 0, state held, stall_cnt +1.
REQ-008 RUN, cond_ex=1 and mem_ready=1: all enables 1, ifid_flush=1, idex_flush=1 for exactly that cycle.
REQ-009 Load-use hazard SHALL be: opcode(ir_ex)=LW, rt(ir_ex)!=0, and rt(ir_ex) equals rs(ir_id) (any non-HLT ID opcode) or rt(ir_id) (R-type or SW in ID).
REQ-010 RUN, hazard, no freeze, no branch: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1; stall_cnt +1; released in the following cycle (single bubble).
REQ-011 RUN, opcode(ir_id)=HLT, no freeze/branch/hazard: pc_en=0, ifid_en=0, idex_flush=1; -> DRAIN with drain counter=3.
REQ-012 Priority: freeze > branch flush > load-use > HLT; HLT in ID with cond_ex=1 is flushed and ignored.
REQ-013 DRAIN: pc_en=0, ifid_en=0, idex_flush=1, idex/exmem/memwb_en=1; counter decrements only when mem_ready=1; mem_ready=0 freezes all enables; at counter 1 with mem_ready=1 -> HALT.
REQ-014 HALT: all enables and flushes 0, halted=1; start ignored; exit only by reset.
REQ-015 stall_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-016 cond_ex, hazard and HLT inputs SHALL be ignored outside RUN (except as stated for DRAIN).

Reset
REQ-017 rst_n=0 at a clock edge SHALL force state IDLE, drain counter 0, stall_cnt 0, from any state including mid-DRAIN or mid-freeze.
REQ-018 During and in the cycle after reset, all enables, flushes, busy and halted SHALL be 0.
REQ-019 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-020 Reset, start=1 one cycle -> next cycle state RUN, all enables 1, busy=1, stall_cnt=0.
REQ-021 ir_ex=LW rt=5, ir_id=ADD rs=5 -> one cycle pc_en=0, ifid_en=0, idex_flush=1, stall_cnt 0->1; next cycle all enables 1.
REQ-022 Same LW with ir_id rt=5 but opcode ADDI -> no stall; LW rt=0 with ADD rs=0 -> no stall.
REQ-023 cond_ex=1 with ir_id=HLT -> both flushes 1 one cycle, state stays RUN.
REQ-024 ir_id=HLT, mem_ready low for 2 cycles in DRAIN -> HALT reached after 5 cycles, halted=1, start=1 then has no effect.
REQ-025 stall_cnt preloaded to 16'hFFFE by holding mem_ready=0 -> reads 16'hFFFF and stays; rst_n=0 mid-DRAIN -> IDLE, outputs 0.

Source files
------------

// File: rtl/mips_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mips_pipe_ctrl
// Brief   : Five-stage pipeline controller: freeze, branch flush, load-use
//           bubble, HLT drain, and a stall-cycle performance counter.
// Rev     : 1.0
// ============================================================================
module mips_pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] ir_id,
    input  logic [31:0] ir_ex,
    input  logic        cond_ex,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        busy,
    output logic        halted,
    output logic [15:0] stall_cnt
);
    localparam logic [5:0] OP_RMAX = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b001000;
    localparam logic [5:0] OP_SW   = 6'b001001;
    localparam logic [5:0] OP_HLT  = 6'b111111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        HALT  = 2'b11
    } state_t;

    state_t     state;
    logic [1:0] drain_cnt;
    logic       bubble_done;

    logic [5:0] op_id;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic [5:0] op_ex;
    logic [4:0] rt_ex;
    logic       id_reads_rt;
    logic       load_use;
    logic       take_bubble;
    logic       id_is_hlt;

    assign op_id = ir_id[31:26];
    assign rs_id = ir_id[25:21];
    assign rt_id = ir_id[20:16];
    assign op_ex = ir_ex[31:26];
    assign rt_ex = ir_ex[20:16];

    assign id_reads_rt = (op_id <= OP_RMAX) || (op_id == OP_SW);
    assign id_is_hlt   = (op_id == OP_HLT);
    assign load_use    = (op_ex == OP_LW) && (rt_ex != 5'd0) &&
                         (((rt_ex == rs_id) && !id_is_hlt) ||
                          ((rt_ex == rt_id) && id_reads_rt));
    // The bubble has already moved the load on; do not stall twice for it.
    assign take_bubble = load_use && !bubble_done;

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        if (rst_n) begin
            busy   = (state == RUN) || (state == DRAIN);
            halted = (state == HALT);
            case (state)
                RUN: begin
                    if (mem_ready) begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                        if (cond_ex) begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end else if (take_bubble || id_is_hlt) begin
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_flush = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_ready) begin
                        idex_en    = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            drain_cnt   <= 2'd0;
            stall_cnt   <= 16'd0;
            bubble_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        stall_cnt   <= 16'd0;
                        bubble_done <= 1'b0;
                    end
                end
                RUN: begin
                    if (!mem_ready) begin
                        if (stall_cnt != 16'hFFFF)
                            stall_cnt <= stall_cnt + 16'd1;
                    end else begin
                        bubble_done <= !cond_ex && take_bubble;
                        if (!cond_ex && take_bubble) begin
                            if (stall_cnt != 16'hFFFF)
                                stall_cnt <= stall_cnt + 16'd1;
                        end else if (!cond_ex && id_is_hlt) begin
                            state     <= DRAIN;
                            drain_cnt <= 2'd3;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_ready) begin
                        drain_cnt <= drain_cnt - 2'd1;
                        if (drain_cnt == 2'd1)
                            state <= HALT;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mips_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_pipe_ctrl
// Brief   : Scoreboard bench for mips_pipe_ctrl with a behavioural model.
// Rev     : 1.0
// ============================================================================
module tb_mips_pipe_ctrl;
    logic        clk = 1'b1;
    logic        rst_n, start, cond_ex, mem_ready;
    logic [31:0] ir_id, ir_ex;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, busy, halted;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    mips_pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir_id(ir_id), .ir_ex(ir_ex),
        .cond_ex(cond_ex), .mem_ready(mem_ready), .pc_en(pc_en),
        .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .busy(busy), .halted(halted), .stall_cnt(stall_cnt)
    );

    localparam logic [5:0] ADD = 6'd0, LW = 6'd8, SW = 6'd9, ADDI = 6'd10,
                           BNEZ = 6'd13, HLT = 6'h3F;

    logic [24:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 run, 2 drain, 3 halt
    int m_state = 0;
    int m_cnt   = 0;
    int m_stall = 0;
    bit m_bub   = 0;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt);
        return {op, rs, rt, 16'h0000};
    endfunction

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic step(input bit chk, input bit r, input bit s, input logic [31:0] id,
                        input logic [31:0] ex, input bit c, input bit mr);
        bit pc, ifd, idx, exm, mwb, fl1, fl2, hz, reads_rs, reads_rt, bsy, hlt;
        int ns, nc, nst;
        bit nb;
        logic [5:0] oi, oe;
        logic [4:0] dst;
        rst_n = r; start = s; ir_id = id; ir_ex = ex; cond_ex = c; mem_ready = mr;
        oi = id[31:26]; oe = ex[31:26]; dst = ex[20:16];
        {pc, ifd, idx, exm, mwb, fl1, fl2} = '0;
        ns = m_state; nc = m_cnt; nst = m_stall; nb = m_bub;
        reads_rs = (oi != HLT);
        reads_rt = (oi <= 6'd5) || (oi == SW);
        hz = (oe == LW) && (dst != 0) && !m_bub &&
             ((reads_rs && dst == id[25:21]) || (reads_rt && dst == id[20:16]));
        bsy = r && (m_state == 1 || m_state == 2);
        hlt = r && (m_state == 3);
        if (!r) begin
            ns = 0; nc = 0; nst = 0; nb = 0;
        end else if (m_state == 0) begin
            if (s) begin ns = 1; nst = 0; nb = 0; end
        end else if (m_state == 1) begin
            if (!mr) nst = sat(m_stall + 1);
            else begin
                {pc, ifd, idx, exm, mwb} = 5'b11111;
                nb = 0;
                if (c) begin
                    fl1 = 1; fl2 = 1;
                end else if (hz) begin
                    pc = 0; ifd = 0; fl2 = 1; nst = sat(m_stall + 1); nb = 1;
                end else if (oi == HLT) begin
                    pc = 0; ifd = 0; fl2 = 1; ns = 2; nc = 3;
                end
            end
        end else if (m_state == 2) begin
            if (mr) begin
                idx = 1; exm = 1; mwb = 1; fl2 = 1;
                nc = m_cnt - 1;
                if (nc == 0) ns = 3;
            end
        end
        if (chk) exp_q.push_back({pc, ifd, idx, exm, mwb, fl1, fl2, bsy, hlt, m_stall[15:0]});
        m_state = ns; m_cnt = nc; m_stall = nst; m_bub = nb;
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are valid every cycle; compare on the falling edge.
    always @(negedge clk) begin
        logic [24:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
                 busy, halted, stall_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t actual=%b required=%b", $time, a, e);
            end
        end
    end

    initial begin
        logic [31:0] nop, rid, rex;
        logic [5:0] pool [6];
        pool[0] = ADD; pool[1] = 6'd3; pool[2] = LW; pool[3] = SW;
        pool[4] = ADDI; pool[5] = BNEZ;
        nop = mk(ADD, 0, 0);

        step(0, 0, 0, nop, nop, 0, 1);                  // bring DUT out of X
        step(1, 0, 1, nop, nop, 0, 1);                  // start during reset ignored
        step(1, 1, 0, nop, nop, 0, 1);                  // still IDLE
        step(1, 1, 1, nop, nop, 0, 1);                  // start
        step(1, 1, 0, nop, nop, 0, 1);                  // RUN, all enables
        step(1, 1, 0, mk(ADD, 5, 1), mk(LW, 2, 5), 0, 1);   // load-use bubble
        step(1, 1, 0, mk(ADD, 5, 1), mk(LW, 2, 5), 0, 1);   // released
        step(1, 1, 0, mk(ADDI, 1, 5), mk(LW, 2, 5), 0, 1);  // ADDI rt not read
        step(1, 1, 0, mk(ADD, 0, 3), mk(LW, 2, 0), 0, 1);   // rt=0 never hazards
        step(1, 1, 0, mk(SW, 1, 7), mk(LW, 2, 7), 0, 1);    // SW reads rt
        step(1, 1, 0, mk(HLT, 0, 0), nop, 1, 1);            // HLT flushed by branch
        step(1, 1, 0, nop, nop, 0, 1);
        for (int i = 0; i < 65540; i++)                     // freeze until saturated
            step(1, 1, 0, mk(HLT, 0, 0), nop, 1, 0);
        step(1, 1, 0, mk(HLT, 0, 0), nop, 0, 1);            // enter DRAIN
        step(1, 1, 0, nop, nop, 0, 0);
        step(1, 1, 0, nop, nop, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, nop, nop, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 1, mk(HLT, 0, 0), nop, 1, 1);  // HALT sticks
        step(1, 0, 0, nop, nop, 0, 1);
        step(1, 1, 1, nop, nop, 0, 1);
        step(1, 1, 0, mk(HLT, 0, 0), nop, 0, 1);
        step(1, 1, 0, nop, nop, 0, 1);                      // mid-DRAIN
        step(1, 0, 0, nop, nop, 0, 1);                      // reset mid-DRAIN
        step(1, 1, 0, nop, nop, 0, 1);

        for (int i = 0; i < 4000; i++) begin
            rid = mk(($urandom_range(0, 19) == 0) ? HLT : pool[$urandom_range(0, 5)],
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            rex = mk(($urandom_range(0, 4) < 2) ? LW : pool[$urandom_range(0, 5)],
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            step(1, $urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0, rid, rex,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
